// File: rtl/regfile_wb_arbiter_if.sv
// ============================================================================
// regfile_wb_arbiter_if : writeback requester / register-file bus bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface regfile_wb_arbiter_if;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        reg_write;
  logic [4:0]  rd;
  logic [31:0] write_data;
  logic [31:0] pending;

  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
           issue_valid, issue_rd,
    input  alu_ready, mem_ready, reg_write, rd, write_data, pending
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
           issue_valid, issue_rd,
    output alu_ready, mem_ready, reg_write, rd, write_data, pending
  );
endinterface

`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
// ============================================================================
// regfile_wb_arbiter : ALU/load writeback arbiter with pending-write scoreboard
// Optional macro WB_RR_EN selects round-robin instead of mem-over-ALU priority.
// Rev 1.0
// ============================================================================
`default_nettype none

module regfile_wb_arbiter #(
  parameter int STALL_CNT_W = 16
) (
  input  wire                    clk,
  input  wire                    rst_n,
  regfile_wb_arbiter_if.slave    bus,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  logic        grant_alu;
  logic        grant_mem;
  logic        both_valid;
  logic        win;
  logic [4:0]  win_rd;
  logic [31:0] win_data;
  logic [31:0] pending_nxt;

  assign both_valid = bus.alu_valid & bus.mem_valid;

`ifdef WB_RR_EN
  // ptr_mem=1 means the load path is preferred on the next conflict
  logic ptr_mem;

  always_comb begin
    grant_alu = bus.alu_valid;
    grant_mem = bus.mem_valid;
    if (both_valid) begin
      grant_alu = ~ptr_mem;
      grant_mem = ptr_mem;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_mem <= 1'b0;
    end else if (both_valid) begin
      ptr_mem <= ~ptr_mem;
    end
  end
`else
  always_comb begin
    grant_mem = bus.mem_valid;
    grant_alu = bus.alu_valid & ~bus.mem_valid;
  end
`endif

  assign bus.alu_ready = rst_n & grant_alu;
  assign bus.mem_ready = rst_n & grant_mem;

  assign win      = bus.alu_ready | bus.mem_ready;
  assign win_rd   = bus.mem_ready ? bus.mem_rd   : bus.alu_rd;
  assign win_data = bus.mem_ready ? bus.mem_data : bus.alu_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.reg_write  <= 1'b0;
      bus.rd         <= 5'd0;
      bus.write_data <= 32'd0;
    end else begin
      bus.reg_write <= win && (win_rd != 5'd0);
      if (win && (win_rd != 5'd0)) begin
        bus.rd         <= win_rd;
        bus.write_data <= win_data;
      end
    end
  end

  // Set is applied after clear so a newer producer of the same rd wins
  always_comb begin
    pending_nxt = bus.pending;
    if (win && (win_rd != 5'd0)) begin
      pending_nxt[win_rd] = 1'b0;
    end
    if (bus.issue_valid && (bus.issue_rd != 5'd0)) begin
      pending_nxt[bus.issue_rd] = 1'b1;
    end
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.pending <= 32'd0;
    end else begin
      bus.pending <= pending_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (both_valid && (stall_cnt != {STALL_CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
// ============================================================================
// tb_regfile_wb_arbiter : directed table-driven bench for regfile_wb_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_regfile_wb_arbiter;

  localparam int SW = 4;

  logic          clk;
  logic          rst_n;
  logic [SW-1:0] stall_cnt;
  int            n_tests;
  int            n_fail;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter #(.STALL_CNT_W(SW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [4:0]  ar;
    logic [31:0] ad;
    logic        mv;
    logic [4:0]  mr;
    logic [31:0] md;
    logic        iv;
    logic [4:0]  ir;
    logic        e_ar;
    logic        e_mr;
    logic        e_rw;
    logic [4:0]  e_rd;
    logic [31:0] e_wd;
    logic [31:0] e_pend;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic mv, input logic [4:0] mr, input logic [31:0] md,
                       input logic iv, input logic [4:0] ir);
    bus.alu_valid   = av;
    bus.alu_rd      = ar;
    bus.alu_data    = ad;
    bus.mem_valid   = mv;
    bus.mem_rd      = mr;
    bus.mem_data    = md;
    bus.issue_valid = iv;
    bus.issue_rd    = ir;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    //         av ar  ad            mv mr  md            iv ir  e_ar e_mr e_rw e_rd  e_wd          e_pend
    tbl[0]  = '{1, 5,  32'hDEADBEEF, 0, 0,  32'h0,        0, 0,  1, 0, 1, 5'd5, 32'hDEADBEEF, 32'h0};
    tbl[1]  = '{0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  0, 0, 0, 5'd5, 32'hDEADBEEF, 32'h0};
    tbl[2]  = '{0, 0,  32'h0,        0, 0,  32'h0,        1, 9,  0, 0, 0, 5'd5, 32'hDEADBEEF, 32'h200};
    tbl[3]  = '{0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  0, 0, 0, 5'd5, 32'hDEADBEEF, 32'h200};
    tbl[4]  = '{0, 0,  32'h0,        1, 9,  32'h11112222, 0, 0,  0, 1, 1, 5'd9, 32'h11112222, 32'h0};
    tbl[5]  = '{1, 9,  32'h33334444, 0, 0,  32'h0,        1, 9,  1, 0, 1, 5'd9, 32'h33334444, 32'h200};
    tbl[6]  = '{0, 0,  32'h0,        1, 9,  32'h55556666, 1, 3,  0, 1, 1, 5'd9, 32'h55556666, 32'h8};
    tbl[7]  = '{1, 0,  32'h1234,     0, 0,  32'h0,        1, 0,  1, 0, 0, 5'd9, 32'h55556666, 32'h8};
    tbl[8]  = '{0, 0,  32'h0,        1, 3,  32'hCAFEF00D, 0, 0,  0, 1, 1, 5'd3, 32'hCAFEF00D, 32'h0};
    tbl[9]  = '{1, 3,  32'h0BADC0DE, 0, 0,  32'h0,        0, 0,  1, 0, 1, 5'd3, 32'h0BADC0DE, 32'h0};
    tbl[10] = '{0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  0, 0, 0, 5'd3, 32'h0BADC0DE, 32'h0};

    // reset state
    #7;
    chk("rst_reg_write", {31'd0, bus.reg_write}, 32'd0);
    chk("rst_rd", {27'd0, bus.rd}, 32'd0);
    chk("rst_write_data", bus.write_data, 32'd0);
    chk("rst_pending", bus.pending, 32'd0);
    chk("rst_stall_cnt", {28'd0, stall_cnt}, 32'd0);
    bus.alu_valid = 1'b1;
    bus.mem_valid = 1'b1;
    #1;
    chk("rst_alu_ready", {31'd0, bus.alu_ready}, 32'd0);
    chk("rst_mem_ready", {31'd0, bus.mem_ready}, 32'd0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      drive(tbl[i].av, tbl[i].ar, tbl[i].ad, tbl[i].mv, tbl[i].mr, tbl[i].md,
            tbl[i].iv, tbl[i].ir);
      #1;
      chk($sformatf("v%0d_alu_ready", i), {31'd0, bus.alu_ready}, {31'd0, tbl[i].e_ar});
      chk($sformatf("v%0d_mem_ready", i), {31'd0, bus.mem_ready}, {31'd0, tbl[i].e_mr});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_reg_write", i), {31'd0, bus.reg_write}, {31'd0, tbl[i].e_rw});
      chk($sformatf("v%0d_rd", i), {27'd0, bus.rd}, {27'd0, tbl[i].e_rd});
      chk($sformatf("v%0d_write_data", i), bus.write_data, tbl[i].e_wd);
      chk($sformatf("v%0d_pending", i), bus.pending, tbl[i].e_pend);
      chk($sformatf("v%0d_stall_cnt", i), {28'd0, stall_cnt}, 32'd0);
    end

    // conflict: both valid for three cycles, then valid drops without transfer
    for (int i = 0; i < 3; i++) begin
      logic exp_mem;
`ifdef WB_RR_EN
      exp_mem = (i == 1);
`else
      exp_mem = 1'b1;
`endif
      @(negedge clk);
      drive(1, 8, 32'hB0B0B0B0, 1, 7, 32'hA0A0A0A0, 0, 0);
      #1;
      chk($sformatf("cf%0d_mem_ready", i), {31'd0, bus.mem_ready}, {31'd0, exp_mem});
      chk($sformatf("cf%0d_alu_ready", i), {31'd0, bus.alu_ready}, {31'd0, ~exp_mem});
      @(posedge clk);
      #1;
      chk($sformatf("cf%0d_rd", i), {27'd0, bus.rd}, exp_mem ? 32'd7 : 32'd8);
      chk($sformatf("cf%0d_write_data", i), bus.write_data,
          exp_mem ? 32'hA0A0A0A0 : 32'hB0B0B0B0);
      chk($sformatf("cf%0d_stall_cnt", i), {28'd0, stall_cnt}, i + 1);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("cf_idle_reg_write", {31'd0, bus.reg_write}, 32'd0);
    chk("cf_idle_stall_cnt", {28'd0, stall_cnt}, 32'd3);

    // asynchronous reset in the middle of a cycle with a write in flight
    @(negedge clk);
    drive(1, 4, 32'h44444444, 0, 0, 0, 1, 12);
    @(posedge clk);
    #1;
    chk("ar_pre_reg_write", {31'd0, bus.reg_write}, 32'd1);
    chk("ar_pre_pending", bus.pending, 32'h1000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_reg_write", {31'd0, bus.reg_write}, 32'd0);
    chk("ar_pending", bus.pending, 32'd0);
    chk("ar_stall_cnt", {28'd0, stall_cnt}, 32'd0);
    chk("ar_alu_ready", {31'd0, bus.alu_ready}, 32'd0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // saturation of the refused-cycle counter
    @(negedge clk);
    drive(1, 1, 32'h1, 1, 2, 32'h2, 0, 0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("sat%0d_stall_cnt", i), {28'd0, stall_cnt},
          (i + 1 > 15) ? 32'd15 : i + 1);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
